note_peak_finder: RTL and testbench

Downstream of the amplitude preprocessor. Takes a snapshot of the smoothed per-note amplitude vector on each `data_v` pulse. Scans the bins one per cycle with circular (octave wrap-around) neighbour comparison and records up to `MAX_PEAKS` local maxima above a floor. Publishes the peak list with a one-cycle valid strobe for the colour/LED mapping stage.

---
 rtl/note_peak_finder.sv | 131 +++++++++++++
 tb/tb_note_peak_finder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_peak_finder.sv
// Circular local-maximum scanner over a captured note-amplitude snapshot.
// One bin per cycle; publishes up to MAX_PEAKS peaks with a one-cycle strobe.

module npf_bin_eval #(
  parameter int AW         = 16,
  parameter int SW         = 18,
  parameter int PEAK_FLOOR = 205
) (
  input  logic [AW-1:0] amp_l,
  input  logic [AW-1:0] amp_c,
  input  logic [AW-1:0] amp_r,
  output logic          is_peak,
  output logic [SW-1:0] sum
);
  localparam logic [AW-1:0] FLOOR = AW'(PEAK_FLOOR);

  // Strict on the left, non-strict on the right: a plateau reports its lowest bin only.
  assign is_peak = (amp_c > amp_l) && (amp_c >= amp_r) && (amp_c >= FLOOR);
  assign sum     = SW'(amp_l) + SW'(amp_c) + SW'(amp_r);
endmodule

module note_peak_finder #(
  parameter int W          = 5,
  parameter int D          = 11,
  parameter int BIN_QTY    = 12,
  parameter int MAX_PEAKS  = 6,
  parameter int PEAK_FLOOR = 205,
  localparam int AW  = W + D,
  localparam int SW  = W + D + 2,
  localparam int PW  = $clog2(BIN_QTY),
  localparam int CW  = $clog2(MAX_PEAKS + 1),
  localparam int SIW = (MAX_PEAKS > 1) ? $clog2(MAX_PEAKS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [BIN_QTY-1:0][AW-1:0]         noteAmplitudes_i,
  input  logic                               data_v,
  output logic [MAX_PEAKS-1:0][PW-1:0]       peakPos_o,
  output logic [MAX_PEAKS-1:0][SW-1:0]       peakAmp_o,
  output logic [CW-1:0]                      peakCount_o,
  output logic                               peakOverflow_o,
  output logic                               peaks_v,
  output logic                               busy_o
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                          state;
  logic [BIN_QTY-1:0][AW-1:0]      snap;
  logic [PW-1:0]                   idx;
  logic [MAX_PEAKS-1:0][PW-1:0]    work_pos;
  logic [MAX_PEAKS-1:0][SW-1:0]    work_amp;
  logic [CW-1:0]                   work_cnt;
  logic                            work_ovf;

  logic [BIN_QTY-1:0]              bin_peak;
  logic [BIN_QTY-1:0][SW-1:0]      bin_sum;
  logic [SIW-1:0]                  slot;

  // Every bin is evaluated against the snapshot in parallel; the scan just walks the results.
  for (genvar b = 0; b < BIN_QTY; b++) begin : g_bin
    npf_bin_eval #(
      .AW(AW), .SW(SW), .PEAK_FLOOR(PEAK_FLOOR)
    ) u_eval (
      .amp_l  (snap[(b + BIN_QTY - 1) % BIN_QTY]),
      .amp_c  (snap[b]),
      .amp_r  (snap[(b + 1) % BIN_QTY]),
      .is_peak(bin_peak[b]),
      .sum    (bin_sum[b])
    );
  end

  assign slot = SIW'(work_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      snap           <= '0;
      idx            <= '0;
      work_pos       <= '0;
      work_amp       <= '0;
      work_cnt       <= '0;
      work_ovf       <= 1'b0;
      peakPos_o      <= '0;
      peakAmp_o      <= '0;
      peakCount_o    <= '0;
      peakOverflow_o <= 1'b0;
      peaks_v        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      peaks_v <= 1'b0;
      case (state)
        S_IDLE: begin
          if (data_v) begin
            snap     <= noteAmplitudes_i;
            work_pos <= '0;
            work_amp <= '0;
            work_cnt <= '0;
            work_ovf <= 1'b0;
            idx      <= '0;
            busy_o   <= 1'b1;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (bin_peak[idx]) begin
            if (work_cnt < CW'(MAX_PEAKS)) begin
              work_pos[slot] <= idx;
              work_amp[slot] <= bin_sum[idx];
              work_cnt       <= work_cnt + CW'(1);
            end else begin
              work_ovf <= 1'b1;
            end
          end
          if (idx == PW'(BIN_QTY - 1)) state <= S_DONE;
          else                         idx   <= idx + PW'(1);
        end
        S_DONE: begin
          // Unused slots were cleared at capture, so they publish as zero.
          peakPos_o      <= work_pos;
          peakAmp_o      <= work_amp;
          peakCount_o    <= work_cnt;
          peakOverflow_o <= work_ovf;
          peaks_v        <= 1'b1;
          busy_o         <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_note_peak_finder.sv
// Random + directed bench for note_peak_finder; two instances (6 and 4 slots)
// checked every cycle against a frame-level peak model.

module tb_note_peak_finder;
  typedef logic [11:0][15:0] frame_t;
  typedef struct packed {
    logic [5:0][3:0]  pos;
    logic [5:0][17:0] amp;
    logic [2:0]       cnt;
    logic             ovf;
  } res_t;

  logic clk = 0;
  logic rst = 1;
  logic data_v = 0;
  frame_t amps = '0;

  logic [5:0][3:0]  pos6;
  logic [5:0][17:0] amp6;
  logic [2:0]       cnt6;
  logic             ovf6, v6, busy6;
  logic [3:0][3:0]  pos4;
  logic [3:0][17:0] amp4;
  logic [2:0]       cnt4;
  logic             ovf4, v4, busy4;

  int nvec = 0;
  int nerr = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  note_peak_finder dut (
    .clk(clk), .rst(rst), .noteAmplitudes_i(amps), .data_v(data_v),
    .peakPos_o(pos6), .peakAmp_o(amp6), .peakCount_o(cnt6),
    .peakOverflow_o(ovf6), .peaks_v(v6), .busy_o(busy6)
  );

  note_peak_finder #(.MAX_PEAKS(4)) dut4 (
    .clk(clk), .rst(rst), .noteAmplitudes_i(amps), .data_v(data_v),
    .peakPos_o(pos4), .peakAmp_o(amp4), .peakCount_o(cnt4),
    .peakOverflow_o(ovf4), .peaks_v(v4), .busy_o(busy4)
  );

  function automatic res_t model(input frame_t f, input int maxp);
    res_t r;
    int n;
    r = '0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      int l, rr;
      l  = (i + 11) % 12;
      rr = (i + 1) % 12;
      if (f[i] > f[l] && f[i] >= f[rr] && f[i] >= 16'd205) begin
        if (n < maxp) begin
          r.pos[n] = 4'(i);
          r.amp[n] = 18'(f[l]) + 18'(f[i]) + 18'(f[rr]);
          n++;
        end else r.ovf = 1'b1;
      end
    end
    r.cnt = 3'(n);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level expectation: a capture produces results 13 edges later; pending means busy.
  bit   pending = 0;
  int   cyc = 0;
  int   due = 0;
  res_t nr6 = '0, nr4 = '0, exp6 = '0, exp4 = '0;
  bit   exp_v = 0;

  always @(posedge clk) begin
    if (rst) begin
      pending <= 0;
      exp6    <= '0;
      exp4    <= '0;
      exp_v   <= 0;
    end else begin
      exp_v <= 0;
      if (pending && cyc == due) begin
        exp6    <= nr6;
        exp4    <= nr4;
        exp_v   <= 1;
        pending <= 0;
      end else if (!pending && data_v) begin
        nr6     <= model(amps, 6);
        nr4     <= model(amps, 4);
        pending <= 1;
        due     <= cyc + 13;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("peaks_v6", 32'(v6), 32'(exp_v));
      chk("busy6", 32'(busy6), 32'(pending));
      chk("cnt6", 32'(cnt6), 32'(exp6.cnt));
      chk("ovf6", 32'(ovf6), 32'(exp6.ovf));
      for (int s = 0; s < 6; s++) begin
        chk($sformatf("pos6[%0d]", s), 32'(pos6[s]), 32'(exp6.pos[s]));
        chk($sformatf("amp6[%0d]", s), 32'(amp6[s]), 32'(exp6.amp[s]));
      end
      chk("peaks_v4", 32'(v4), 32'(exp_v));
      chk("busy4", 32'(busy4), 32'(pending));
      chk("cnt4", 32'(cnt4), 32'(exp4.cnt));
      chk("ovf4", 32'(ovf4), 32'(exp4.ovf));
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("pos4[%0d]", s), 32'(pos4[s]), 32'(exp4.pos[s]));
        chk($sformatf("amp4[%0d]", s), 32'(amp4[s]), 32'(exp4.amp[s]));
      end
    end
  end

  task automatic send_frame(input frame_t f);
    @(negedge clk);
    amps   = f;
    data_v = 1;
    @(negedge clk);
    data_v = 0;
  endtask

  // Called right after send_frame; returns negedges until the strobe (bounded).
  task automatic wait_v(output int k);
    k = 0;
    while (!v6 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < 12; i++) begin
      case (mode)
        0:       f[i] = 16'($urandom_range(0, 3) * 100);
        1:       f[i] = 16'($urandom);
        default: f[i] = 16'($urandom_range(200, 210));
      endcase
    end
    return f;
  endfunction

  initial begin
    frame_t f;
    int k;
    repeat (2) @(negedge clk);
    checking = 1;
    @(negedge clk);
    rst = 0;

    // Four-bin plateau starting at bin 0
    f = '0;
    for (int i = 0; i < 4; i++) f[i] = 16'hFFFF;
    send_frame(f);
    wait_v(k);
    chk("lit_latency", 32'(k), 32'd13);
    chk("lit_plateau_cnt", 32'(cnt6), 32'd1);
    chk("lit_plateau_pos0", 32'(pos6[0]), 32'd0);
    chk("lit_plateau_amp0", 32'(amp6[0]), 32'h1FFFE);
    chk("lit_plateau_ovf", 32'(ovf6), 32'd0);
    chk("lit_plateau_amp1", 32'(amp6[1]), 32'd0);

    // Wrap-around neighbours
    f = '0; f[11] = 16'h0800; f[0] = 16'h0400; f[10] = 16'h0100;
    send_frame(f);
    wait_v(k);
    chk("lit_wrap_cnt", 32'(cnt6), 32'd1);
    chk("lit_wrap_pos", 32'(pos6[0]), 32'd11);
    chk("lit_wrap_amp", 32'(amp6[0]), 32'h0D00);

    // Floor boundary
    f = '0; f[5] = 16'd204;
    send_frame(f);
    wait_v(k);
    chk("lit_floor204_cnt", 32'(cnt6), 32'd0);
    f[5] = 16'd205;
    send_frame(f);
    wait_v(k);
    chk("lit_floor205_cnt", 32'(cnt6), 32'd1);
    chk("lit_floor205_pos", 32'(pos6[0]), 32'd5);
    chk("lit_floor205_amp", 32'(amp6[0]), 32'd205);

    // Alternating peaks: full on 6 slots, overflow on 4
    f = '0;
    for (int i = 0; i < 12; i += 2) f[i] = 16'h1000;
    send_frame(f);
    wait_v(k);
    chk("lit_alt_cnt6", 32'(cnt6), 32'd6);
    chk("lit_alt_ovf6", 32'(ovf6), 32'd0);
    chk("lit_alt_cnt4", 32'(cnt4), 32'd4);
    chk("lit_alt_ovf4", 32'(ovf4), 32'd1);
    for (int s = 0; s < 4; s++) chk($sformatf("lit_alt_pos4[%0d]", s), 32'(pos4[s]), 32'(2 * s));
    f[1] = 16'h0800; f[2] = 16'h0400;
    send_frame(f);
    wait_v(k);

    // Second data_v during scan is dropped; new vector also changes the input bus
    f = '0; f[3] = 16'h2000;
    send_frame(f);
    repeat (4) @(negedge clk);
    amps = rnd_frame();
    data_v = 1;
    @(negedge clk);
    data_v = 0;
    wait_v(k);
    chk("lit_drop_pos", 32'(pos6[0]), 32'd3);
    repeat (20) @(negedge clk);

    // Reset mid-scan, then a normal frame
    send_frame(rnd_frame());
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("lit_rst_cnt", 32'(cnt6), 32'd0);
    send_frame(rnd_frame());
    wait_v(k);
    chk("lit_after_rst_latency", 32'(k), 32'd13);

    // Reset coinciding with data_v
    @(negedge clk);
    amps = rnd_frame(); data_v = 1; rst = 1;
    @(negedge clk);
    data_v = 0; rst = 0;
    repeat (3) @(negedge clk);

    // Random traffic: captures, drops, input churn and occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) amps = rnd_frame();
      rst = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    data_v = 0; rst = 0;
    repeat (20) @(negedge clk);
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
